// File: rtl/interp_pkg.sv
// Shared definitions for the 2x linear interpolation datapath: default sample
// width and the upsampler's state encoding.
package interp_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MID  = 2'd1,
        ORIG = 2'd2
    } state_e;

endpackage

// File: rtl/interp_avg.sv
// Combinational two-sample average (a+b)>>1, summed at WIDTH+1 bits so the
// carry is kept and the result truncates toward zero.
module interp_avg #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] avg_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        avg_o = WIDTH'(sum >> 1);
    end

endmodule

// File: rtl/interp2_upsampler.sv
// Streaming 2x linear interpolator: each accepted sample x yields the midpoint
// (prev + x) >> 1 followed by x itself, with valid/ready on both sides.
//
// Handshake: a transfer happens on a rising CLK edge where valid && ready.
// out_* is registered and held while out_valid && !out_ready. in_ready is
// combinational from out_ready in the ORIG state so a new sample can be taken
// on the same edge the original is consumed.
module interp2_upsampler
    import interp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_phase
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] avg_a;
    logic [WIDTH-1:0] mid;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // In ORIG the sample being emitted becomes the new history on this edge.
    assign avg_a = (state_q == ORIG) ? cur_q : prev_q;

    interp_avg #(
        .WIDTH(WIDTH)
    ) u_avg (
        .a_i  (avg_a),
        .b_i  (in_data),
        .avg_o(mid)
    );

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = MID;
                end
            end
            MID: begin
                if (out_fire) begin
                    state_d = ORIG;
                end
            end
            ORIG: begin
                if (out_fire) begin
                    state_d = in_fire ? MID : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_phase = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            MID: begin
                out_valid = 1'b1;
            end
            ORIG: begin
                out_valid = 1'b1;
                out_phase = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    always_comb begin
        prev_d = prev_q;
        cur_d  = cur_q;
        data_d = data_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    cur_d  = in_data;
                    data_d = mid;
                end
            end
            MID: begin
                if (out_fire) begin
                    data_d = cur_q;
                end
            end
            ORIG: begin
                if (out_fire) begin
                    prev_d = cur_q;
                    if (in_fire) begin
                        cur_d  = in_data;
                        data_d = mid;
                    end
                end
            end
            default: begin
                data_d = data_q;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rstn) begin
        if (!rstn) begin
            prev_q <= '0;
            cur_q  <= '0;
            data_q <= '0;
        end else begin
            prev_q <= prev_d;
            cur_q  <= cur_d;
            data_q <= data_d;
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_interp2_upsampler.sv
// Self-checking bench for interp2_upsampler: table of two-sample streams plus
// hand-written reset, backpressure, throughput and idle-gap sequences.
module tb_interp2_upsampler;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_phase;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [W:0]   exp_q[$];
    logic [W:0]   obs_q[$];
    int           obs_cyc_q[$];
    logic [W-1:0] model_prev = '0;

    typedef struct {
        logic [W-1:0] x0;
        logic [W-1:0] x1;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        logic [W-1:0] e3;
    } vec_t;

    vec_t tbl[7];

    interp2_upsampler #(
        .WIDTH(W)
    ) dut (
        .CLK      (CLK),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_phase(out_phase)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [W-1:0] model_mid(input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        s = int'(a) + int'(b);
        return W'(s / 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expectations are queued on input accept, compared on output consume.
    always @(negedge CLK) begin
        if (rstn) begin
            if (out_valid && out_ready) begin
                obs_q.push_back({out_phase, out_data});
                obs_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%0d required=none", {out_phase, out_data});
                end else begin
                    chk("sb_data", 32'({out_phase, out_data}), 32'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, model_mid(model_prev, in_data)});
                exp_q.push_back({1'b1, in_data});
                model_prev = in_data;
            end
        end
    end

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rstn = 1'b0;
        exp_q.delete();
        model_prev = '0;
        #3;
        rstn = 1'b1;
        sync();
        obs_q.delete();
        obs_cyc_q.delete();
    endtask

    task automatic send(input logic [W-1:0] x);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = x;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge CLK);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
        sync();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge CLK);
            if (!out_valid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=out_valid_high required=idle");
        end
        sync();
    endtask

    task automatic chk_obs(input string name, input int n, input logic [W-1:0] d0,
                           input logic [W-1:0] d1, input logic [W-1:0] d2, input logic [W-1:0] d3);
        logic [W-1:0] d[4];
        d[0] = d0;
        d[1] = d1;
        d[2] = d2;
        d[3] = d3;
        chk({name, "_count"}, 32'(obs_q.size()), 32'(n));
        for (int i = 0; i < n && i < obs_q.size(); i++) begin
            chk({name, "_out"}, 32'(obs_q[i]), 32'({1'(i % 2), d[i]}));
        end
    endtask

    initial begin
        tbl[0] = '{8'd255, 8'd255, 8'd127, 8'd255, 8'd255, 8'd255};
        tbl[1] = '{8'd3,   8'd4,   8'd1,   8'd3,   8'd3,   8'd4};
        tbl[2] = '{8'd10,  8'd20,  8'd5,   8'd10,  8'd15,  8'd20};
        tbl[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
        tbl[4] = '{8'd1,   8'd0,   8'd0,   8'd1,   8'd0,   8'd0};
        tbl[5] = '{8'd200, 8'd100, 8'd100, 8'd200, 8'd150, 8'd100};
        tbl[6] = '{8'd254, 8'd255, 8'd127, 8'd254, 8'd254, 8'd255};

        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_phase", 32'(out_phase), 0);
        #10;
        rstn = 1'b1;
        sync();

        // Single sample: latency and phase ordering.
        out_ready = 1'b1;
        send(8'd8);
        @(negedge CLK);
        chk("single_mid_valid", 32'(out_valid), 1);
        chk("single_mid", 32'({out_phase, out_data}), 32'({1'b0, 8'd4}));
        @(negedge CLK);
        chk("single_orig", 32'({out_phase, out_data}), 32'({1'b1, 8'd8}));
        @(negedge CLK);
        chk("single_idle_valid", 32'(out_valid), 0);
        sync();

        for (int v = 0; v < 7; v++) begin
            do_reset();
            out_ready = 1'b1;
            send(tbl[v].x0);
            send(tbl[v].x1);
            drain();
            chk_obs($sformatf("tbl%0d", v), 4, tbl[v].e0, tbl[v].e1, tbl[v].e2, tbl[v].e3);
        end

        // Back-to-back: six outputs on consecutive cycles.
        do_reset();
        out_ready = 1'b1;
        send(8'd10);
        send(8'd20);
        send(8'd30);
        drain();
        chk("b2b_count", 32'(obs_q.size()), 6);
        if (obs_q.size() == 6) begin
            chk("b2b_o0", 32'(obs_q[0]), 32'({1'b0, 8'd5}));
            chk("b2b_o1", 32'(obs_q[1]), 32'({1'b1, 8'd10}));
            chk("b2b_o2", 32'(obs_q[2]), 32'({1'b0, 8'd15}));
            chk("b2b_o3", 32'(obs_q[3]), 32'({1'b1, 8'd20}));
            chk("b2b_o4", 32'(obs_q[4]), 32'({1'b0, 8'd25}));
            chk("b2b_o5", 32'(obs_q[5]), 32'({1'b1, 8'd30}));
            for (int i = 1; i < 6; i++) begin
                chk("b2b_gap", 32'(obs_cyc_q[i] - obs_cyc_q[i-1]), 1);
            end
        end

        // Backpressure: MID output held stable, new input refused.
        do_reset();
        out_ready = 1'b0;
        send(8'd100);
        in_valid = 1'b1;
        in_data = 8'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_hold", 32'({out_phase, out_data}), 32'({1'b0, 8'd50}));
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        sync();
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk_obs("bp", 2, 8'd50, 8'd100, 8'd0, 8'd0);

        // Idle gap keeps prev.
        do_reset();
        out_ready = 1'b1;
        send(8'd40);
        drain();
        repeat (5) @(posedge CLK);
        #1;
        send(8'd60);
        drain();
        chk_obs("gap", 4, 8'd20, 8'd40, 8'd50, 8'd60);

        // Asynchronous reset mid-stream discards the pending sample.
        do_reset();
        out_ready = 1'b1;
        send(8'd200);
        out_ready = 1'b0;
        @(negedge CLK);
        chk("arst_pre_valid", 32'(out_valid), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_out_phase", 32'(out_phase), 0);
        exp_q.delete();
        model_prev = '0;
        #1;
        rstn = 1'b1;
        sync();
        obs_q.delete();
        obs_cyc_q.delete();
        out_ready = 1'b1;
        send(8'd8);
        drain();
        chk_obs("arst_restart", 2, 8'd4, 8'd8, 8'd0, 8'd0);
        chk("sb_leftover", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
